// File: rtl/bus_rr_scheduler.sv
// Round-robin bus controller: grants one pending driver FIFO, pops a packet and routes it
// (unicast or broadcast) into the receive FIFOs. Optional counters under BUS_STATS_EN.
module bus_rr_scheduler #(
  parameter int unsigned drvrs     = 4,
  parameter int unsigned pckg_sz   = 16,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [drvrs-1:0]           pndng,
  input  logic [drvrs*pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]           pop,
  input  logic [drvrs-1:0]           full,
  output logic [drvrs-1:0]           push,
  output logic [pckg_sz-1:0]         D_push,
  output logic [$clog2(drvrs)-1:0]   grant_id,
  output logic                       busy,
  output logic                       drop
`ifdef BUS_STATS_EN
  ,
  output logic [drvrs*16-1:0]        grant_cnt,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int unsigned id_w = $clog2(drvrs);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_ROUTE, S_PUSH} state_t;

  state_t              state, state_n;
  logic [id_w-1:0]     ptr, ptr_n;
  logic [id_w-1:0]     grant_n;
  logic [pckg_sz-1:0]  pkt, pkt_n;
  logic [drvrs-1:0]    pop_n, push_n;
  logic [pckg_sz-1:0]  dpush_n;
  logic                busy_n, drop_n;

  logic                sel_found;
  logic [id_w-1:0]     sel_id, cand;
  logic [7:0]          dest;
  logic                dest_ok;
  logic [drvrs-1:0]    mask;
  logic [id_w-1:0]     nxt_id;

  // First pending source at or after ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < drvrs; k++) begin
      cand = id_w'((32'(ptr) + k) % drvrs);
      if (!sel_found && pndng[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Destination decode of the held packet into a receive-FIFO mask.
  always_comb begin
    dest    = pkt[pckg_sz-1 -: 8];
    dest_ok = 1'b0;
    mask    = '0;
    if (dest == broadcast) begin
      dest_ok = 1'b1;
      mask    = ~(drvrs'(1) << grant_id);
    end else if (32'(dest) < drvrs && dest != 8'(grant_id)) begin
      dest_ok = 1'b1;
      mask    = drvrs'(1) << dest;
    end
  end

  assign nxt_id = (grant_id == id_w'(drvrs - 1)) ? '0 : grant_id + id_w'(1);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant_id;
    pkt_n   = pkt;
    pop_n   = '0;
    push_n  = '0;
    dpush_n = D_push;
    drop_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_found) begin
          grant_n = sel_id;
          pop_n   = drvrs'(1) << sel_id;
          state_n = S_POP;
        end
      end
      S_POP: begin
        for (int unsigned i = 0; i < drvrs; i++)
          if (grant_id == id_w'(i)) pkt_n = D_pop[i*pckg_sz +: pckg_sz];
        state_n = S_ROUTE;
      end
      S_ROUTE: begin
        if (!dest_ok) begin
          drop_n  = 1'b1;
          ptr_n   = nxt_id;
          state_n = S_IDLE;
        end else if ((mask & full) == '0) begin
          push_n  = mask;
          dpush_n = pkt;
          state_n = S_PUSH;
        end
      end
      S_PUSH: begin
        ptr_n   = nxt_id;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      grant_id <= '0;
      pkt      <= '0;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      busy     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      grant_id <= grant_n;
      pkt      <= pkt_n;
      pop      <= pop_n;
      push     <= push_n;
      D_push   <= dpush_n;
      busy     <= busy_n;
      drop     <= drop_n;
    end
  end

`ifdef BUS_STATS_EN
  // Saturating per-source grant counts and drop count.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      for (int unsigned i = 0; i < drvrs; i++)
        if (state == S_PUSH && grant_id == id_w'(i) && grant_cnt[i*16 +: 16] != 16'hFFFF)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Scoreboard bench for bus_rr_scheduler: source FIFO model, expected pop/push/drop queues,
// and a negedge monitor comparing DUT strobes against them.
module tb_bus_rr_scheduler;
  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   pndng = '0;
  logic [N*W-1:0] D_pop = '0;
  logic [N-1:0]   full = '0;
  logic [N-1:0]   pop, push;
  logic [W-1:0]   D_push;
  logic [1:0]     grant_id;
  logic           busy, drop;
`ifdef BUS_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     drop_cnt;
`endif

  bus_rr_scheduler #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .full(full),
    .push(push), .D_push(D_push), .grant_id(grant_id), .busy(busy), .drop(drop)
`ifdef BUS_STATS_EN
    , .grant_cnt(grant_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           src;
    logic [N-1:0] mask;
    logic [W-1:0] data;
    int           lat;
    int           at;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;
  exp_t exp_pop[$];
  exp_t exp_push[$];
  int   exp_drop[$];
  logic [W-1:0] srcq [N][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Source FIFOs: head leaves on the edge that ends the pop cycle.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++)
      if (pop[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      pndng[i] = (srcq[i].size() != 0);
      D_pop[i*W +: W] = pndng[i] ? srcq[i][0] : '0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (!reset) begin
      if (pop != '0) begin
        last_pop_cyc = cyc;
        if (exp_pop.size() == 0) chk("unexpected_pop", 64'(pop), 64'd0);
        else begin
          e = exp_pop.pop_front();
          chk("pop_mask", 64'(pop), 64'(N'(1) << e.src));
          chk("pop_grant_id", 64'(grant_id), 64'(e.src));
          if (e.at != 0) chk("pop_cycle", 64'(cyc), 64'(e.at));
        end
      end
      if (push != '0) begin
        if (exp_push.size() == 0) chk("unexpected_push", 64'(push), 64'd0);
        else begin
          e = exp_push.pop_front();
          chk("push_mask", 64'(push), 64'(e.mask));
          chk("push_data", 64'(D_push), 64'(e.data));
          chk("push_grant_id", 64'(grant_id), 64'(e.src));
          if (e.lat != 0) chk("push_latency", 64'(cyc - last_pop_cyc), 64'(e.lat));
          if (e.at != 0) chk("push_cycle", 64'(cyc), 64'(e.at));
        end
      end
      if (drop) begin
        if (exp_drop.size() == 0) chk("unexpected_drop", 64'(drop), 64'd0);
        else begin
          d = exp_drop.pop_front();
          chk("drop_grant_id", 64'(grant_id), 64'(d));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic exp_p(input int s, input int at);
    exp_pop.push_back('{src: s, mask: '0, data: '0, lat: 0, at: at});
  endtask

  task automatic exp_u(input int s, input logic [N-1:0] m, input logic [W-1:0] d,
                       input int lat, input int at);
    exp_push.push_back('{src: s, mask: m, data: d, lat: lat, at: at});
  endtask

  initial begin
    int bc;
    reset = 1'b1;
    tick(3);
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_push", 64'(push), 64'd0);
    chk("rst_d_push", 64'(D_push), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    reset = 1'b0;

    // Single packet 0 -> 2
    srcq[0].push_back(16'h02AB);
    exp_p(0, cyc + 1);
    exp_u(0, 4'b0100, 16'h02AB, 2, 0);
    bc = 0;
    repeat (10) begin
      @(negedge clk);
      bc += int'(busy);
    end
    chk("single_busy_cycles", 64'(bc), 64'd3);
    chk("d_push_hold", 64'(D_push), 64'h02AB);
    tick();

    // Round-robin with all sources pending
    do_reset();
    srcq[0].push_back(16'h0100);
    srcq[0].push_back(16'h0144);
    srcq[1].push_back(16'h0211);
    srcq[2].push_back(16'h0322);
    srcq[3].push_back(16'h0033);
    exp_p(0, cyc + 1);
    exp_p(1, cyc + 5);
    exp_p(2, cyc + 9);
    exp_p(3, cyc + 13);
    exp_p(0, cyc + 17);
    exp_u(0, 4'b0010, 16'h0100, 2, cyc + 3);
    exp_u(1, 4'b0100, 16'h0211, 2, cyc + 7);
    exp_u(2, 4'b1000, 16'h0322, 2, cyc + 11);
    exp_u(3, 4'b0001, 16'h0033, 2, cyc + 15);
    exp_u(0, 4'b0010, 16'h0144, 2, cyc + 19);
    tick(26);

    // Broadcast from source 2
    srcq[2].push_back(16'hFF55);
    exp_p(2, 0);
    exp_u(2, 4'b1011, 16'hFF55, 2, 0);
    tick(10);

    // Backpressure on destination 3
    full[3] = 1'b1;
    srcq[0].push_back(16'h0377);
    exp_p(0, 0);
    tick(12);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_push", 64'(push), 64'd0);
    full[3] = 1'b0;
    exp_u(0, 4'b1000, 16'h0377, 0, cyc + 1);
    tick(6);

    // Invalid destinations from source 1
    srcq[1].push_back(16'h0701);
    srcq[1].push_back(16'h0102);
    exp_p(1, 0);
    exp_p(1, 0);
    exp_drop.push_back(1);
    exp_drop.push_back(1);
    tick(14);
`ifdef BUS_STATS_EN
    chk("drop_cnt", 64'(drop_cnt), 64'd2);
`endif

    // Reset while stalled in ROUTE
    full[0] = 1'b1;
    srcq[3].push_back(16'h0099);
    exp_p(3, 0);
    tick(5);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    chk("pre_reset_grant", 64'(grant_id), 64'd3);
    do_reset();
    chk("mid_rst_push", 64'(push), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_grant_id", 64'(grant_id), 64'd0);
    chk("mid_rst_pop", 64'(pop), 64'd0);
    full[0] = 1'b0;
    srcq[0].push_back(16'h01AA);
    srcq[3].push_back(16'h00BB);
    exp_p(0, cyc + 1);
    exp_p(3, cyc + 5);
    exp_u(0, 4'b0010, 16'h01AA, 2, 0);
    exp_u(3, 4'b0001, 16'h00BB, 2, 0);
    tick(14);

    chk("pending_pops", 64'(exp_pop.size()), 64'd0);
    chk("pending_pushes", 64'(exp_push.size()), 64'd0);
    chk("pending_drops", 64'(exp_drop.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_rr_scheduler.md
Name: bus_rr_scheduler

Overview:
- Round-robin scheduler that shares one broadcast-capable packet bus among `drvrs` FIFO-backed drivers.
- Per packet: grants one pending source, pops one packet from it, decodes the destination ID and pushes the packet to the destination receive FIFO(s), honouring their full flags.
- Sits between the driver-side FIFOs and the receive-side FIFOs as the bus controller.

Parameters:
- drvrs, 4, number of drivers/ports (2..16).
- pckg_sz, 16, packet width in bits; destination ID is bits [pckg_sz-1 -: 8].
- broadcast, 8'hFF, destination ID value meaning "all ports except source".

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pndng  in  drvrs  bit i = source FIFO i non-empty; its head word is valid on D_pop (first-word fall-through).
- D_pop  in  drvrs*pckg_sz  flattened head words; port i occupies [i*pckg_sz +: pckg_sz].
- pop  out  drvrs  one-hot, 1-cycle pop strobe to the granted source.
- full  in  drvrs  bit i = receive FIFO i cannot accept a word.
- push  out  drvrs  push strobe mask to receive FIFOs (one-hot, or multi-hot for broadcast).
- D_push  out  pckg_sz  packet driven to all receive FIFOs; valid while push != 0.
- grant_id  out  $clog2(drvrs)  index of the current or last granted source.
- busy  out  1  high in every state except IDLE.
- drop  out  1  1-cycle pulse when a packet is discarded.

Behaviour:
- Reset values:
  - pop=0, push=0, D_push=0, grant_id=0, busy=0, drop=0.
  - Round-robin pointer ptr=0; state=IDLE.
- FSM states: IDLE, POP, ROUTE, PUSH.
- IDLE:
  - If pndng != 0, select the first i with pndng[i]=1, searching from ptr upward with wrap modulo drvrs.
  - Register grant_id=i and go to POP.
  - Otherwise stay in IDLE.
- POP:
  - pop[grant_id]=1 for exactly one cycle.
  - Latch pkt = D_pop slice of grant_id in the same cycle; go to ROUTE.
- ROUTE:
  - Decode dest = pkt[pckg_sz-1 -: 8] into a target mask:
    - dest == broadcast: mask = all ones with bit grant_id cleared.
    - dest < drvrs and dest != grant_id: mask = one-hot(dest).
    - Otherwise (out of range, or self-addressed): drop=1 for 1 cycle, return to IDLE, set ptr = grant_id+1 mod drvrs.
  - If (mask & full) != 0, stay in ROUTE (stall, packet held); for broadcast, all targets must be non-full simultaneously.
  - Otherwise go to PUSH.
- PUSH:
  - push=mask and D_push=pkt for exactly one cycle.
  - Set ptr = grant_id+1 mod drvrs; go to IDLE.
- Latency: 4 cycles per packet minimum (IDLE→POP→ROUTE→PUSH); push is asserted 2 cycles after pop absent stalls.
- Fairness: a source waits at most drvrs-1 other grants.
- pndng changes after the grant decision do not affect the grant in progress.
- full is sampled only in ROUTE; a full change during PUSH is ignored.
- reset asserted in any state:
  - Next cycle is IDLE with all outputs at their reset values.
  - The in-flight packet is lost; no partial push.
- D_push holds the last pushed value between pushes.

Optional Feature:
- Macro: BUS_STATS_EN.
- When defined:
  - Adds output grant_cnt, drvrs*16 bits, flattened; count i occupies [i*16 +: 16].
  - Count i increments in the PUSH cycle for source i and saturates at 16'hFFFF.
  - Adds output drop_cnt, 16 bits, incrementing on each drop pulse and saturating at 16'hFFFF.
  - All counts clear on reset.
- When undefined: neither port nor any counter logic exists.

Test Plan:
- Single packet: pndng=4'b0001, D_pop[0]=16'h02AB → pop[0] in cycle 2 after reset release, push=4'b0100 with D_push=16'h02AB two cycles later; busy high for 3 cycles.
- Round-robin: all four sources pending continuously, each to dest (src+1)%4 → grant order 0,1,2,3,0; one push every 4 cycles.
- Broadcast: source 2 sends 16'hFF55 → single push=4'b1011, D_push=16'hFF55.
- Backpressure: dest 3 with full[3]=1 for 10 cycles → FSM holds in ROUTE, no push; push[3] fires 1 cycle after full[3] drops to 0.
- Invalid destination: source 1 sends 16'h07xx, then 16'h01xx → each gives pop[1] then a drop pulse, no push; drop_cnt=2 with BUS_STATS_EN.
- Reset mid-transfer: assert reset during ROUTE → next cycle push=0, busy=0, grant_id=0; the next grant starts the search from source 0.
